switch_debounce4: RTL and testbench
===================================

// Module: switch_debounce4
// PURPOSE
//   Conditions four raw, asynchronous board switch/button inputs for the 4-input AND stage.
//   Each channel gets a 2-flop synchronizer, then a counter-based debouncer.
//   Emits clean, glitch-free levels plus one-cycle change strobes.
//   Sits directly upstream of the AND gate: sw_db[0..3] drive its a,b,c,d inputs.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  consecutive cycles a new level must persist before acceptance (5 ms @ 100 MHz); legal >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width (derived; do not override)
// PORTS
//   clk      in   1  single system clock; all state on rising edge
//   rst_n    in   1  reset, asynchronous assert, active-low
//   sw_raw   in   4  raw switch levels, asynchronous to clk, may bounce
//   sw_db    out  4  debounced levels; bit i -> AND input (0:a 1:b 2:c 3:d)
//   chg      out  4  1-cycle pulse on the cycle sw_db[i] updates
//   any_chg  out  1  OR of chg
// BEHAVIOUR
//   Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//     While rst_n=0: sync flops=0, sw_db=0, chg=0, any_chg=0, every channel in STABLE, counters=0.
//     Reset mid-count abandons the pending change. Channel restarts from sw_db=0.
//   Synchronizer: sync1<=sw_raw; sync2<=sync1. Only sync2 is seen by the FSM. No combinational path from sw_raw to outputs.
//   Per-channel FSM (states STABLE, COUNT):
//     STABLE: cnt=0.
//       If sync2 != sw_db: go to COUNT, cnt<=1.
//     COUNT, sync2 == sw_db (bounce back): go to STABLE, cnt<=0, no output change.
//     COUNT, sync2 != sw_db, cnt == DEBOUNCE_CYCLES-1: sw_db<=sync2, chg pulses 1 cycle, go to STABLE, cnt<=0.
//     COUNT, other cases: cnt<=cnt+1.
//   Result: sw_db changes only after sync2 has differed from it on DEBOUNCE_CYCLES consecutive edges.
//   Latency: raw level held steady -> sw_db update = DEBOUNCE_CYCLES+2 clock edges.
//   Pulse filtering: a raw pulse shorter than DEBOUNCE_CYCLES cycles (after sync) never reaches sw_db.
//   chg/any_chg: registered; high exactly on the cycle sw_db holds its new value. any_chg = |chg, same cycle.
//   Channels are fully independent. Simultaneous changes on several bits each complete on their own timeline.
//     Equal timing gives chg with multiple bits set in one cycle.
//   Counter never wraps: max value DEBOUNCE_CYCLES-1, fits CNT_W.
//   Toggle landing on the exact acceptance cycle: evaluation uses the sync2 value at that edge.
//   All outputs come straight from flops (glitch-free into the AND stage).
// STRUCTURE
//   Package lab2_pkg:
//     typedef enum logic {DB_STABLE, DB_COUNT} db_state_t;
//     localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
//   Sub-module debounce_channel (1-bit: sync2 in; db, chg out; parameter DEBOUNCE_CYCLES).
//     Instantiated 4x via generate.
//   Top owns the 4-bit synchronizer flops and the any_chg OR.
// TESTING (bench uses DEBOUNCE_CYCLES=8)
//   1 Reset: rst_n=0 with sw_raw=4'hF, mid-run -> sw_db=0, chg=0 immediately (async); held until release.
//   2 Clean edge: sw_raw[2] 0->1, held -> sw_db[2]=1 at edge 10 after change.
//       chg=4'b0100 and any_chg=1 for exactly that cycle. Other bits unchanged.
//   3 Bounce: sw_raw[0] toggles 1,0,1,0 with 3-cycle pulses, then stays 1.
//       -> sw_db[0] stays 0 until 10 edges after the final rise, then goes 1. Exactly one chg pulse.
//   4 Short glitch: sw_raw[1]=1 for 5 cycles, then back to 0 -> sw_db[1] never changes, chg never asserts.
//   5 Simultaneous: sw_raw 4'h0->4'hF in one cycle -> sw_db=4'hF at edge 10; chg=4'hF for one cycle.
//       sw_db feeding the AND gives f=1 only after that edge.
//   6 Reset mid-count: sw_raw[3]=1, rst_n pulsed low at cycle 6 of the count.
//       -> sw_db[3]=0. After release, sw_db[3]=1 exactly 10 edges later (full re-count).

Source files
------------

// File: rtl/lab2_pkg.sv
// Shared types and defaults for the four-channel switch debouncer.
package lab2_pkg;

    typedef enum logic {DB_STABLE, DB_COUNT} db_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned NUM_LANES               = 4;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: accepts a new synchronized level only after it has
// differed from the current output on DEBOUNCE_CYCLES consecutive edges.
module debounce_channel
    import lab2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic db,
    output logic chg,
    output logic chg_nxt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             db_nxt;
    logic             differ, accept;

    assign differ = (sync_in != db);
    assign accept = (state == DB_COUNT) && differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DB_STABLE;
            cnt   <= '0;
            db    <= 1'b0;
            chg   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            db    <= db_nxt;
            chg   <= chg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DB_STABLE: if (differ) state_nxt = DB_COUNT;
            DB_COUNT:  if (!differ || accept) state_nxt = DB_STABLE;
            default:   state_nxt = DB_STABLE;
        endcase
    end

    // Counter never exceeds CNT_LAST: acceptance or bounce-back clears it first.
    always_comb begin
        cnt_nxt = '0;
        db_nxt  = db;
        chg_nxt = 1'b0;
        case (state)
            DB_STABLE: if (differ) cnt_nxt = CNT_W'(1);
            DB_COUNT: begin
                if (accept) begin
                    db_nxt  = sync_in;
                    chg_nxt = 1'b1;
                end else if (differ) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

endmodule

// File: rtl/switch_debounce4.sv
// Four raw switch inputs -> 2-flop synchronizers -> per-lane debouncers.
// Every output is a flop so the downstream AND stage never sees glitches.
module switch_debounce4
    import lab2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] sw_raw,
    output logic [NUM_LANES-1:0] sw_db,
    output logic [NUM_LANES-1:0] chg,
    output logic                 any_chg
);

    logic [NUM_LANES-1:0] sync1, sync2;
    logic [NUM_LANES-1:0] chg_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sync_in (sync2[i]),
            .db      (sw_db[i]),
            .chg     (chg[i]),
            .chg_nxt (chg_nxt[i])
        );
    end

    // Registered from the lanes' next-state strobes so it lines up with chg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_chg <= 1'b0;
        else        any_chg <= |chg_nxt;
    end

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed, table-driven and randomized checks of switch_debounce4 (N=8).
module tb_switch_debounce4;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw_raw = 4'h0;
    logic [3:0] sw_db, chg;
    logic       any_chg;

    int tests = 0;
    int fails = 0;

    switch_debounce4 #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
        .sw_db(sw_db), .chg(chg), .any_chg(any_chg)
    );

    always #5 clk = ~clk;

    // Reference: each lane flips once its synchronized input has disagreed
    // with the output for N edges in a row.
    logic [3:0] m_s1, m_s2, m_db, m_chg;
    int         m_run [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_chg = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            m_chg = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == N) begin
                        m_db[i] = m_s2[i]; m_chg[i] = 1'b1; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_db", sw_db, m_db);
        chk("model_chg", chg, m_chg);
        chk("model_any", {3'b0, any_chg}, {3'b0, |m_chg});
    end

    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] exp_db;
    } vec_t;

    vec_t vecs [6];
    int   pulses;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{4'h1, 12, 4'h1};
        vecs[1] = '{4'h3, 12, 4'h3};
        vecs[2] = '{4'h2, 3,  4'h3};
        vecs[3] = '{4'h2, 12, 4'h2};
        vecs[4] = '{4'h0, 9,  4'h2};
        vecs[5] = '{4'h0, 1,  4'h0};

        // Reset state
        sw_raw = 4'hF;
        wait_n(3);
        chk("reset_db", sw_db, 4'h0);
        chk("reset_chg", chg, 4'h0);
        sw_raw = 4'h0;
        rst_n = 1'b1;
        wait_n(3);

        // Table-driven sequence
        for (int k = 0; k < 6; k++) begin
            sw_raw = vecs[k].raw;
            wait_n(vecs[k].hold);
            chk($sformatf("vec%0d_db", k), sw_db, vecs[k].exp_db);
        end
        wait_n(4);

        // Clean edge on bit 2
        sw_raw = 4'h4;
        wait_n(9);
        chk("clean_pre_db", sw_db, 4'h0);
        chk("clean_pre_chg", chg, 4'h0);
        wait_n(1);
        chk("clean_db", sw_db, 4'h4);
        chk("clean_chg", chg, 4'h4);
        chk("clean_any", {3'b0, any_chg}, 4'h1);
        wait_n(1);
        chk("clean_post_chg", chg, 4'h0);

        // Short glitch on bit 1
        sw_raw = 4'h6;
        wait_n(5);
        sw_raw = 4'h4;
        for (int c = 0; c < 15; c++) begin
            wait_n(1);
            chk("glitch_db", sw_db, 4'h4);
            chk("glitch_chg", chg, 4'h0);
        end

        // Bounce on bit 0: 3-cycle pulses, then stays high
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            sw_raw = (b % 2 == 0) ? 4'h5 : 4'h4;
            for (int c = 0; c < 3; c++) begin
                wait_n(1);
                if (chg[0]) pulses++;
            end
        end
        sw_raw = 4'h5;
        wait_n(9);
        if (chg[0]) pulses++;
        chk("bounce_pre_db", sw_db, 4'h4);
        wait_n(1);
        if (chg[0]) pulses++;
        chk("bounce_db", sw_db, 4'h5);
        wait_n(3);
        if (chg[0]) pulses++;
        chk("bounce_pulses", 4'(pulses), 4'h1);

        // Simultaneous 0 -> F
        sw_raw = 4'h0;
        wait_n(14);
        sw_raw = 4'hF;
        wait_n(9);
        chk("simul_pre_db", sw_db, 4'h0);
        chk("simul_pre_and", {3'b0, &sw_db}, 4'h0);
        wait_n(1);
        chk("simul_db", sw_db, 4'hF);
        chk("simul_chg", chg, 4'hF);
        chk("simul_and", {3'b0, &sw_db}, 4'h1);
        wait_n(1);
        chk("simul_post_chg", chg, 4'h0);

        // Async reset mid-count
        sw_raw = 4'h0;
        wait_n(4);
        #2 rst_n = 1'b0;
        sw_raw = 4'hF;
        #1;
        chk("async_db", sw_db, 4'h0);
        chk("async_chg", chg, 4'h0);
        wait_n(3);
        chk("async_hold_db", sw_db, 4'h0);
        sw_raw = 4'h0;
        rst_n = 1'b1;
        wait_n(12);

        // Reset at count cycle 6 on bit 3 forces a full re-count
        sw_raw = 4'h8;
        wait_n(8);
        #2 rst_n = 1'b0;
        #1 chk("recount_rst_db", sw_db, 4'h0);
        wait_n(1);
        rst_n = 1'b1;
        wait_n(9);
        chk("recount_pre_db", sw_db, 4'h0);
        wait_n(1);
        chk("recount_db", sw_db, 4'h8);
        chk("recount_chg", chg, 4'h8);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 9) == 0) sw_raw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end
        wait_n(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
